glitc_i2c_target: RTL and testbench



---
 rtl/glitc_i2c_pkg.sv | 27 ++
 rtl/glitc_i2c_line_filter.sv | 50 +++++
 rtl/glitc_i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_glitc_i2c_target.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitc_i2c_pkg.sv
// Shared types and constants for the GLITC I2C target.
package glitc_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) w++;
        return w;
    endfunction

endpackage

// File: rtl/glitc_i2c_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter with edge strobes.
module glitc_i2c_line_filter
    import glitc_i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic user_clk_i,
    input  logic user_rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (clog2(FILTER_LEN) > 0) ? clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          flip;

    always_comb begin
        differ = (sync_q[1] != level_o);
        flip   = differ && (cnt_q == CW'(FILTER_LEN - 1));
    end

    // Strobes are registered alongside the level so both are seen in the same cycle.
    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_o <= 1'b1;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_o <= flip && sync_q[1];
            fall_o <= flip && !sync_q[1];
            if (flip) begin
                level_o <= sync_q[1];
                cnt_q   <= '0;
            end else if (differ) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/glitc_i2c_target.sv
// I2C target exposing a byte register file with pointer/auto-increment access.
module glitc_i2c_target
    import glitc_i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR   = 7'h60,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic                    user_clk_i,
    input  logic                    user_rst_i,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_o,
    output logic                    sda_oen_o,
    output logic [8*NUM_REGS-1:0]   reg_dat_o,
    output logic                    reg_wr_o,
    output logic [7:0]              reg_wr_addr_o,
    output logic                    busy_o
);

    localparam int unsigned PW = clog2(NUM_REGS);

    logic scl_lvl, scl_rise_raw, scl_fall_raw;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_ev, stop_ev, scl_rise, scl_fall;

    i2c_state_t    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          byte_full_q, byte_full_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          oen_q, oen_d;
    logic          busy_q, busy_d;
    logic          wr_en;
    logic [7:0]    rd_byte;
    logic [7:0]    regs_q [NUM_REGS];

    glitc_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .user_clk_i (user_clk_i),
        .user_rst_i (user_rst_i),
        .line_i     (scl_i),
        .level_o    (scl_lvl),
        .rise_o     (scl_rise_raw),
        .fall_o     (scl_fall_raw)
    );

    glitc_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .user_clk_i (user_clk_i),
        .user_rst_i (user_rst_i),
        .line_i     (sda_i),
        .level_o    (sda_lvl),
        .rise_o     (sda_rise),
        .fall_o     (sda_fall)
    );

    always_comb begin
        start_ev = sda_fall && scl_lvl;
        stop_ev  = sda_rise && scl_lvl;
        scl_rise = scl_rise_raw && !start_ev && !stop_ev;
        scl_fall = scl_fall_raw && !start_ev && !stop_ev;
        rd_byte  = regs_q[ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_full_d = byte_full_q;
        ptr_d       = ptr_q;
        oen_d       = oen_q;
        busy_d      = busy_q;
        wr_en       = 1'b0;

        if (stop_ev) begin
            state_d = IDLE;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_ev) begin
            state_d     = ADDR;
            oen_d       = 1'b1;
            bit_cnt_d   = '0;
            byte_full_d = 1'b0;
        end else begin
            // Receive states and RDATA share the bit counter; byte_full marks the 8th rise.
            if (scl_rise && (state_q inside {ADDR, PTR, WDATA, RDATA})) begin
                if (state_q != RDATA) shift_d = {shift_q[6:0], sda_lvl};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
            end

            case (state_q)
                ADDR: begin
                    if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        if (shift_q[7:1] == I2C_ADDR && shift_q[7:1] != 7'd0) begin
                            state_d = ADDR_ACK;
                            oen_d   = I2C_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d   = '0;
                        byte_full_d = 1'b0;
                        if (shift_q[0]) begin
                            state_d = RDATA;
                            shift_d = rd_byte;
                            oen_d   = rd_byte[7];
                        end else begin
                            state_d = PTR;
                            oen_d   = 1'b1;
                        end
                    end
                end
                PTR: begin
                    if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        ptr_d       = shift_q[PW-1:0];
                        oen_d       = I2C_ACK;
                        state_d     = PTR_ACK;
                    end
                end
                WDATA: begin
                    if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        wr_en       = 1'b1;
                        ptr_d       = ptr_q + PW'(1);
                        oen_d       = I2C_ACK;
                        state_d     = WDATA_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        oen_d   = 1'b1;
                        state_d = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (byte_full_q) begin
                            byte_full_d = 1'b0;
                            oen_d       = 1'b1;
                            state_d     = RACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oen_d   = shift_q[6];
                        end
                    end
                end
                RACK: begin
                    // byte_full here records that the controller ACKed the byte.
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = WAIT_STOP;
                        end else begin
                            byte_full_d = 1'b1;
                            ptr_d       = ptr_q + PW'(1);
                        end
                    end else if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        bit_cnt_d   = '0;
                        shift_d     = rd_byte;
                        oen_d       = rd_byte[7];
                        state_d     = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_full_q   <= 1'b0;
            ptr_q         <= '0;
            oen_q         <= 1'b1;
            busy_q        <= 1'b0;
            reg_wr_o      <= 1'b0;
            reg_wr_addr_o <= '0;
            regs_q        <= '{default: '0};
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_full_q <= byte_full_d;
            ptr_q       <= ptr_d;
            oen_q       <= oen_d;
            busy_q      <= busy_d;
            reg_wr_o    <= wr_en;
            if (wr_en) begin
                regs_q[ptr_q] <= shift_q;
                reg_wr_addr_o <= 8'(ptr_q);
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_REGS; k++) reg_dat_o[8*k +: 8] = regs_q[k];
    end

    assign sda_o     = 1'b0;
    assign sda_oen_o = oen_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_glitc_i2c_target.sv
// Directed bench: bit-banged I2C controller against glitc_i2c_target.
module tb_glitc_i2c_target;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned Q        = 10;

    logic                  user_clk_i = 1'b0;
    logic                  user_rst_i = 1'b1;
    logic                  scl_m      = 1'b1;
    logic                  sda_m      = 1'b1;
    logic                  sda_bus;
    logic                  sda_o, sda_oen_o, reg_wr_o, busy_o;
    logic [8*NUM_REGS-1:0] reg_dat_o;
    logic [7:0]            reg_wr_addr_o;

    int        n_cmp = 0;
    int        n_err = 0;
    int        oen_low = 0;
    int        busy_high = 0;
    bit        watch = 1'b0;
    bit        glitch = 1'b0;
    logic      sampled;
    logic [7:0] wr_q[$];

    assign sda_bus = sda_m & (sda_oen_o ? 1'b1 : sda_o);

    glitc_i2c_target #(
        .I2C_ADDR   (7'h60),
        .NUM_REGS   (NUM_REGS),
        .FILTER_LEN (3)
    ) dut (
        .user_clk_i    (user_clk_i),
        .user_rst_i    (user_rst_i),
        .scl_i         (scl_m),
        .sda_i         (sda_bus),
        .sda_o         (sda_o),
        .sda_oen_o     (sda_oen_o),
        .reg_dat_o     (reg_dat_o),
        .reg_wr_o      (reg_wr_o),
        .reg_wr_addr_o (reg_wr_addr_o),
        .busy_o        (busy_o)
    );

    always #5 user_clk_i = ~user_clk_i;

    always @(negedge user_clk_i) begin
        if (reg_wr_o) wr_q.push_back(reg_wr_addr_o);
        if (watch && !sda_oen_o) oen_low++;
        if (watch && busy_o) busy_high++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge user_clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rg(input int k);
        return reg_dat_o[8*k +: 8];
    endfunction

    function automatic logic [7:0] wr_at(input int i);
        return (wr_q.size() > i) ? wr_q[i] : 8'hFF;
    endfunction

    task automatic bit_out(input logic b);
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        if (glitch) begin
            cyc(2); sda_m = ~sda_m; cyc(1); sda_m = ~sda_m;
            cyc(2); scl_m = 1'b0;   cyc(1); scl_m = 1'b1;
            cyc(2); sda_m = ~sda_m; cyc(2); sda_m = ~sda_m;
            cyc(2); scl_m = 1'b0;   cyc(2); scl_m = 1'b1;
        end else begin
            cyc(14);
        end
        sampled = sda_bus;
        cyc(6);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_out(1'b1);
        ack = sampled;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1);
            d[i] = sampled;
        end
        bit_out(ack);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_idx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1;
        logic [7:0] addr_b;

        vecs[0] = '{8'hC0, 8'h2F, 8'h77, 1'b0, 15};
        vecs[1] = '{8'hC0, 8'h07, 8'h3C, 1'b0, 7};
        vecs[2] = '{8'hC0, 8'h1A, 8'h96, 1'b0, 10};
        vecs[3] = '{8'h00, 8'h01, 8'hEE, 1'b1, -1};
        vecs[4] = '{8'hC4, 8'h02, 8'hDD, 1'b1, -1};

        cyc(5);
        chk("rst oen", 32'(sda_oen_o), 32'd1);
        chk("rst sda_o", 32'(sda_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst wr", 32'(reg_wr_o), 32'd0);
        chk("rst wr_addr", 32'(reg_wr_addr_o), 32'd0);
        chk("rst regs", 32'(|reg_dat_o), 32'd0);
        user_rst_i = 1'b0;
        cyc(10);

        // Plain write of two bytes
        wr_q.delete();
        i2c_start();
        write_byte(8'hC0, a0); write_byte(8'h03, a1);
        write_byte(8'hA5, a2); write_byte(8'h5A, a3);
        chk("wr acks", 32'({a0, a1, a2, a3}), 32'd0);
        chk("wr busy", 32'(busy_o), 32'd1);
        i2c_stop();
        chk("wr busy stop", 32'(busy_o), 32'd0);
        chk("wr reg3", 32'(rg(3)), 32'hA5);
        chk("wr reg4", 32'(rg(4)), 32'h5A);
        chk("wr pulses", 32'(wr_q.size()), 32'd2);
        chk("wr addr0", 32'(wr_at(0)), 32'd3);
        chk("wr addr1", 32'(wr_at(1)), 32'd4);

        // Combined read with repeated START
        wr_q.delete();
        i2c_start();
        write_byte(8'hC0, a0); write_byte(8'h03, a1);
        i2c_rstart();
        write_byte(8'hC1, a2);
        chk("rd acks", 32'({a0, a1, a2}), 32'd0);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        chk("rd byte0", 32'(d0), 32'hA5);
        chk("rd byte1", 32'(d1), 32'h5A);
        chk("rd release", 32'(sda_oen_o), 32'd1);
        chk("rd busy", 32'(busy_o), 32'd1);
        i2c_stop();
        chk("rd busy stop", 32'(busy_o), 32'd0);
        chk("rd no wr", 32'(wr_q.size()), 32'd0);

        // Address mismatch
        wr_q.delete();
        oen_low = 0; busy_high = 0; watch = 1'b1;
        i2c_start();
        write_byte(8'hC2, a0); write_byte(8'h00, a1); write_byte(8'hFF, a2);
        i2c_stop();
        watch = 1'b0;
        chk("mm acks", 32'({a0, a1, a2}), 32'h7);
        chk("mm oen low", 32'(oen_low), 32'd0);
        chk("mm busy", 32'(busy_high), 32'd0);
        chk("mm no wr", 32'(wr_q.size()), 32'd0);

        // Pointer wrap
        wr_q.delete();
        i2c_start();
        write_byte(8'hC0, a0); write_byte(8'h0F, a1);
        write_byte(8'h11, a2); write_byte(8'h22, a3);
        i2c_stop();
        chk("wrap acks", 32'({a0, a1, a2, a3}), 32'd0);
        chk("wrap reg15", 32'(rg(15)), 32'h11);
        chk("wrap reg0", 32'(rg(0)), 32'h22);
        chk("wrap addr0", 32'(wr_at(0)), 32'd15);
        chk("wrap addr1", 32'(wr_at(1)), 32'd0);

        // Single-byte write vectors
        for (int v = 0; v < 5; v++) begin
            wr_q.delete();
            i2c_start();
            write_byte(vecs[v].addr, a0);
            write_byte(vecs[v].ptr, a1);
            write_byte(vecs[v].data, a2);
            i2c_stop();
            chk($sformatf("vec%0d acks", v), 32'({a0, a1, a2}), {29'd0, {3{vecs[v].exp_ack}}});
            if (vecs[v].exp_idx >= 0) begin
                chk($sformatf("vec%0d reg", v), 32'(rg(vecs[v].exp_idx)), 32'(vecs[v].data));
                chk($sformatf("vec%0d wr addr", v), 32'(wr_at(0)), 32'(vecs[v].exp_idx));
                chk($sformatf("vec%0d pulses", v), 32'(wr_q.size()), 32'd1);
            end else begin
                chk($sformatf("vec%0d no wr", v), 32'(wr_q.size()), 32'd0);
            end
        end

        // Glitches on both lines during every SCL-high phase
        wr_q.delete();
        glitch = 1'b1;
        i2c_start();
        write_byte(8'hC0, a0); write_byte(8'h05, a1); write_byte(8'hC3, a2);
        glitch = 1'b0;
        i2c_stop();
        chk("gl acks", 32'({a0, a1, a2}), 32'd0);
        chk("gl reg5", 32'(rg(5)), 32'hC3);
        chk("gl addr", 32'(wr_at(0)), 32'd5);
        chk("gl pulses", 32'(wr_q.size()), 32'd1);

        // Abort: STOP mid-byte
        wr_q.delete();
        i2c_start();
        write_byte(8'hC0, a0); write_byte(8'h03, a1);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        i2c_stop();
        chk("ab acks", 32'({a0, a1}), 32'd0);
        chk("ab no wr", 32'(wr_q.size()), 32'd0);
        chk("ab reg3", 32'(rg(3)), 32'hA5);
        chk("ab busy", 32'(busy_o), 32'd0);

        // Abort: reset while the target drives the address ACK
        addr_b = 8'hC0;
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(addr_b[i]);
        chk("ab2 ack drive", 32'(sda_oen_o), 32'd0);
        chk("ab2 busy", 32'(busy_o), 32'd1);
        user_rst_i = 1'b1;
        #1;
        chk("ab2 rst oen", 32'(sda_oen_o), 32'd1);
        chk("ab2 rst busy", 32'(busy_o), 32'd0);
        chk("ab2 rst regs", 32'(|reg_dat_o), 32'd0);
        scl_m = 1'b1; sda_m = 1'b1;
        cyc(3);
        user_rst_i = 1'b0;
        cyc(10);
        chk("ab2 regs after", 32'(|reg_dat_o), 32'd0);
        chk("ab2 oen after", 32'(sda_oen_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
